// File: rtl/spi_regfile_rw.sv
// SPI mode-0 peripheral owning NUM_REGS x DATA_W configuration registers.
// Frame: R/W bit (1=write), ADDR_W address bits, DATA_W data bits, MSB first,
// sampled on sclk rise. Reads shift the addressed register out on cipo,
// and writes commit one clk after the last data bit is seen.
// Output contract: wr_strobe is a single-cycle pulse. It is qualified by
// nothing else, and wr_addr and regs_out are already updated in that cycle.
module spi_regfile_rw #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [2:0]                   state_o
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  // The shift register only has to hold R/W+address or the data word.
  localparam int SH_W      = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_RDATA = 3'd2,
    S_WDATA = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, copi_sync_q;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   sclk_prev_q, ncs_prev_q;
  logic                   sclk_s, ncs_s, copi_s, edges_en;
  logic                   sclk_rise, sclk_fall, ncs_fall, ncs_rise, sclk_act;

  logic [CNT_W-1:0]       bit_cnt_q;
  logic [SH_W-2:0]        shift_q;
  logic [SH_W-1:0]        shift_d;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   commit_pend_q;
  logic                   last_addr_bit, last_data_bit;

  logic [DATA_W-1:0]      tx_q;
  logic                   cipo_q;
  logic [DATA_W-1:0]      rd_val;
  logic                   wr_hit;

  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic                   wr_strobe_q;
  logic [ADDR_W-1:0]      wr_addr_q;

  // Input synchronisers, edge-history copies and a fill tracker. Edges stay
  // masked until the pipeline holds real pin samples, so an ncs held low
  // through reset release is not seen as a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '1;
      copi_sync_q <= '0;
      vld_q       <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign edges_en  = vld_q[SYNC_STAGES];
  assign sclk_rise = edges_en &  sclk_s & ~sclk_prev_q;
  assign sclk_fall = edges_en & ~sclk_s &  sclk_prev_q;
  assign ncs_fall  = edges_en & ~ncs_s  &  ncs_prev_q;
  assign ncs_rise  = edges_en &  ncs_s  & ~ncs_prev_q;
  // A chip-select edge takes priority over any sclk edge in the same cycle.
  assign sclk_act  = sclk_rise & ~ncs_rise & ~ncs_fall;

  assign shift_d       = {shift_q, copi_s};
  assign last_addr_bit = (bit_cnt_q == CNT_W'(ADDR_W));
  assign last_data_bit = (bit_cnt_q == CNT_W'(FRAME_LEN - 1));

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: ncs rise aborts, ncs fall (re)starts, sclk rises advance.
  always_comb begin
    state_d = state_q;
    if (ncs_rise) begin
      state_d = S_IDLE;
    end else if (ncs_fall) begin
      state_d = S_ADDR;
    end else if (sclk_rise) begin
      case (state_q)
        S_ADDR:  if (last_addr_bit) state_d = shift_d[ADDR_W] ? S_WDATA : S_RDATA;
        S_WDATA: if (last_data_bit) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Read mux over implemented registers; unimplemented addresses read as 0.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shift_d[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i];
    end
  end

  // Decide whether the pending write targets an implemented register.
  always_comb begin
    wr_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) wr_hit = 1'b1;
    end
  end

  // Receive path: bit counter, shift register, captured address and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      commit_pend_q <= 1'b0;
    end else begin
      commit_pend_q <= 1'b0;
      if (ncs_fall) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end else if (sclk_act && (state_q == S_ADDR || state_q == S_WDATA)) begin
        shift_q   <= shift_d[SH_W-2:0];
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (state_q == S_ADDR && last_addr_bit) addr_q <= shift_d[ADDR_W-1:0];
        if (state_q == S_WDATA && last_data_bit) begin
          wdata_q       <= shift_d[DATA_W-1:0];
          commit_pend_q <= 1'b1;
        end
      end
    end
  end

  // Transmit path: load the read value with the last address bit, then
  // present one bit per sclk fall, MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      cipo_q <= 1'b0;
    end else if (sclk_act && state_q == S_ADDR && last_addr_bit) begin
      tx_q <= rd_val;
    end else if (state_q == S_RDATA && sclk_fall && !ncs_rise) begin
      cipo_q <= tx_q[DATA_W-1];
      tx_q   <= tx_q << 1;
    end
  end

  // Write commit: independent of the FSM so a same-cycle ncs rise cannot stop it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (commit_pend_q && wr_hit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_q == ADDR_W'(i)) regs_q[i] <= wdata_q;
        end
        wr_strobe_q <= 1'b1;
        wr_addr_q   <= addr_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo      = cipo_q;
  assign cipo_oe   = (state_q == S_RDATA) & ~ncs_s;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign state_o   = state_q;

endmodule
